irq_arbiter: RTL and testbench

- Collects up to N_SRC external interrupt lines and arbitrates among them.
- Presents a single registered ExtIRQ request, plus the winning source ID, to the single-cycle processor's controller.
- Sequences the request / ExtIAck handshake and holds the processor "in service" until the handler's ERET.
- Sits between the SoC interrupt sources and the processor top level. Nested interrupts are not supported.

---
 rtl/irq_arbiter.sv | 62 ++++++
 tb/tb_irq_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-triggered interrupt collector with fixed-priority arbitration
// and a request / acknowledge / ERET handshake toward the processor controller.
module irq_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ExtIAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] src_ack
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t           state_q, state_d;
  logic [N_SRC-1:0] prev_q, pending_q, pending_d, ack_q, ack_d, eligible;
  logic [ID_W-1:0]  id_q, id_d, win;
  always_comb begin
    eligible = pending_q & ~irq_mask;
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) win = eligible[i] ? ID_W'(i) : win;
    ack_d = (state_q == REQ && ExtIAck) ? N_SRC'(1) << id_q : '0;
    // a fresh edge overrides the clear from the acknowledge
    pending_d = (pending_q & ~ack_d) | (irq_src & ~prev_q);
    state_d = state_q;
    id_d = id_q;
    case (state_q)
      IDLE: begin
        state_d = |eligible ? REQ : IDLE;
        id_d = |eligible ? win : id_q;
      end
      REQ:     state_d = ExtIAck ? SERVICE : REQ;
      SERVICE: state_d = ERet ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q <= '0;
      pending_q <= '0;
      ack_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= irq_src;
      pending_q <= pending_d;
      ack_q <= ack_d;
      id_q <= id_d;
    end
  end
  assign ExtIRQ = state_q == REQ;
  assign in_service = state_q == SERVICE;
  assign irq_id = id_q;
  assign pending = pending_q;
  assign src_ack = ack_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed plus random stimulus, reference model feeding a scoreboard queue.
module tb_irq_arbiter;
  localparam int N = 4;
  logic clk = 0, reset = 1, ExtIAck = 0, ERet = 0;
  logic [N-1:0] irq_src = 0, irq_mask = 0, pending, src_ack;
  logic ExtIRQ, in_service;
  logic [1:0] irq_id;
  int n_chk = 0, n_pass = 0;
  logic [11:0] sb[$];

  irq_arbiter #(.N_SRC(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .irq_mask(irq_mask),
    .ExtIAck(ExtIAck), .ERet(ERet), .ExtIRQ(ExtIRQ), .irq_id(irq_id),
    .in_service(in_service), .pending(pending), .src_ack(src_ack)
  );

  always #5 clk = ~clk;

  // reference: phase 0 = waiting, 1 = requesting, 2 = handler running
  int m_phase = 0, lo;
  logic [1:0] m_id = 0;
  logic [N-1:0] m_prev = 0, m_pend = 0, m_ack = 0, ev;
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_id = 0; m_prev = 0; m_pend = 0; m_ack = 0;
    end else begin
      ev = irq_src & ~m_prev;
      m_prev = irq_src;
      m_ack = 0;
      lo = -1;
      for (int i = 0; i < N; i++) if (lo < 0 && m_pend[i] && !irq_mask[i]) lo = i;
      if (m_phase == 0 && lo >= 0) begin
        m_id = 2'(lo);
        m_phase = 1;
      end else if (m_phase == 1 && ExtIAck) begin
        m_ack[m_id] = 1'b1;
        m_pend[m_id] = 1'b0;
        m_phase = 2;
      end else if (m_phase == 2 && ERet) m_phase = 0;
      m_pend = m_pend | ev;
      sb.push_back({m_phase == 1, m_id, m_phase == 2, m_pend, m_ack});
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      logic [11:0] e, a;
      e = sb.pop_front();
      a = {ExtIRQ, irq_id, in_service, pending, src_ack};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL scoreboard t=%0t {irq,id,svc,pend,ack} got %h expected %h", $time, a, e);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic [N-1:0] s, input logic [N-1:0] m, input logic a, input logic e);
    irq_src = s; irq_mask = m; ExtIAck = a; ERet = e;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {ExtIRQ, irq_id, in_service, src_ack}, 8'h0);
    chk("reset_pending", 8'(pending), 8'h0);
    reset = 0;
    step(4'b0100, 0, 0, 0);
    chk("t1_pend_E0", 8'(pending), 8'h4);
    chk("t1_noirq_E0", 8'(ExtIRQ), 8'h0);
    step(0, 0, 0, 0);
    chk("t1_irq_E1", {ExtIRQ, 5'b0, irq_id}, 8'h82);
    repeat (5) step(0, 0, 0, 0);
    chk("t1_irq_held", 8'(ExtIRQ), 8'h1);
    step(0, 0, 1, 0);
    chk("t1_ack", {src_ack, pending}, 8'h40);
    chk("t1_svc", {ExtIRQ, in_service}, 8'h1);
    step(0, 0, 0, 0);
    chk("t1_ack_pulse", 8'(src_ack), 8'h0);
    step(4'b1010, 0, 1, 0);
    chk("t2_pend", {3'b0, ExtIRQ, pending}, 8'h0a);
    step(0, 0, 0, 1);
    chk("t2_idle", {ExtIRQ, in_service}, 8'h0);
    step(0, 0, 0, 0);
    chk("t2_req1", {ExtIRQ, 5'b0, irq_id}, 8'h81);
    step(0, 0, 1, 0);
    chk("t2_pend3", 8'(pending), 8'h8);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t2_req3", {ExtIRQ, 5'b0, irq_id}, 8'h83);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(4'b0101, 4'b0001, 0, 0);
    step(0, 4'b0001, 0, 0);
    chk("t3_masked_req", {ExtIRQ, 5'b0, irq_id}, 8'h82);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t3_id_held", {ExtIRQ, 5'b0, irq_id}, 8'h82);
    step(0, 0, 1, 0);
    chk("t3_ack2", 8'(src_ack), 8'h4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t3_req0", {ExtIRQ, 5'b0, irq_id}, 8'h80);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(4'b0010, 0, 0, 0);
    step(0, 0, 0, 0);
    step(4'b0010, 0, 1, 0);
    chk("t4_set_wins", {src_ack, pending}, 8'h22);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t4_rereq1", {ExtIRQ, 5'b0, irq_id}, 8'h81);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(4'b0110, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_pre_reset", {ExtIRQ, 3'b0, pending}, 8'h86);
    reset = 1;
    #1;
    chk("t5_async_reset", {ExtIRQ, in_service, irq_id, pending}, 8'h0);
    irq_src = 4'b0001;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("t5_edge_after_reset", 8'(pending), 8'h1);
    for (int k = 0; k < 1500; k++)
      step(4'($urandom & $urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
